mul_iter: RTL

Iterative 32x32 multiplier for the EX-stage multiply/divide unit of the dynamic pipeline. It pairs with the iterative divider and uses the same start/busy/finish/cpu_stall handshake, so the pipeline control drives both units identically. It computes a 64-bit signed (MULT) or unsigned (MULTU) product with one shift-add step per cycle, and delivers the result as HI/LO words.

---
 rtl/mul_iter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mul_iter.sv
// Iterative shift-add 32x32 multiplier (MULT/MULTU) with start/busy/finish/cpu_stall handshake.
// Optional MUL_ZERO_BYPASS_EN: a zero operand skips the iteration and completes immediately.
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic             cpu_stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             finish
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   acc_hi, acc_lo;
    logic [CW-1:0]      cnt;

    logic               start_sign_a, start_sign_b;
    logic [WIDTH-1:0]   start_mag_a, start_mag_b;
    logic               bypass;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc, product;

    // Operands are reduced to magnitudes; the sign is re-applied once at DONE.
    assign start_sign_a = signed_op & multiplicand[WIDTH-1];
    assign start_sign_b = signed_op & multiplier[WIDTH-1];
    assign start_mag_a  = start_sign_a ? -multiplicand : multiplicand;
    assign start_mag_b  = start_sign_b ? -multiplier   : multiplier;

`ifdef MUL_ZERO_BYPASS_EN
    assign bypass = (start_mag_a == '0) || (start_mag_b == '0);
`else
    assign bypass = 1'b0;
`endif

    // One shift-add step: conditional add into the upper half with a carry bit.
    assign sum     = {1'b0, acc_hi} + ({1'b0, mag_a} & {(WIDTH + 1){acc_lo[0]}});
    assign acc     = {acc_hi, acc_lo};
    assign product = (sign_a ^ sign_b) ? -acc : acc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
        state_next = state;
        if (start) begin
            state_next = bypass ? DONE : RUN;
        end else begin
            case (state)
                RUN:     if (!cpu_stall && cnt == CNT_LAST) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = state;
            endcase
        end
    end

    // NOTE: all registered state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            mag_a  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            finish <= 1'b0;
        end else begin
            finish <= 1'b0;
            if (start) begin
                // A new start aborts anything in flight, including a pending DONE write.
                sign_a <= start_sign_a;
                sign_b <= start_sign_b;
                mag_a  <= start_mag_a;
                acc_hi <= '0;
                acc_lo <= bypass ? '0 : start_mag_b;
                cnt    <= '0;
                busy   <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        if (!cpu_stall) begin
                            acc_hi <= sum[WIDTH:1];
                            acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
                            cnt    <= cnt + CW'(1);
                        end
                    end
                    DONE: begin
                        hi     <= product[2*WIDTH-1:WIDTH];
                        lo     <= product[WIDTH-1:0];
                        finish <= 1'b1;
                        busy   <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
